// File: rtl/tt_um_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : tt_um_lfsr
// Description : 16-bit Galois LFSR pseudo-random generator in a TinyTapeout
//               user tile. Free-running or single-step advance, byte-wise
//               seed load from the uio pins, all-zero lock-up guard,
//               period-wrap detection and a selectable output byte.
//
// Ports       : clk      - system clock, rising edge
//               rst      - synchronous reset, active high
//               ena      - tile enable; 0 holds all LFSR state
//               ui_in    - [0] run, [1] step, [2] load_lo, [3] load_hi,
//                          [5:4] out_sel, [7:6] reserved
//               uo_out   - selected output byte
//               uio_in   - seed byte for loads
//               uio_out  - constant 8'h00
//               uio_oe   - constant 8'h00 (all uio pins are inputs)
//
// Build option: LFSR_HISTORY_EN - when defined, an 8-bit history register of
//               shifted-out LSBs is kept and returned on out_sel = 2'b11;
//               otherwise out_sel = 2'b11 reads 8'h00.
//
// Revision    : 1.0 - initial release
// ============================================================================
module tt_um_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1,
    parameter logic [15:0] TAPS = 16'hB400
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [1:0] c_SEL_LO     = 2'b00;
    localparam logic [1:0] c_SEL_HI     = 2'b01;
    localparam logic [1:0] c_SEL_STATUS = 2'b10;

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    logic       w_run;
    logic       w_step;
    logic       w_load_lo;
    logic       w_load_hi;
    logic [1:0] w_out_sel;
    logic       w_unused_rsvd;

    assign w_run         = ui_in[0];
    assign w_step        = ui_in[1];
    assign w_load_lo     = ui_in[2];
    assign w_load_hi     = ui_in[3];
    assign w_out_sel     = ui_in[5:4];
    assign w_unused_rsvd = &{1'b0, ui_in[7:6]};

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [15:0] r_state;
    logic [15:0] r_start;      // state the current period began from
    logic        r_zero;
    logic        r_wrap;
    logic        r_step_prev;

    // ------------------------------------------------------------------
    // Next-state helpers
    // ------------------------------------------------------------------
    logic        w_step_pulse;
    logic        w_load;
    logic        w_advance;
    logic [15:0] w_next;
    logic [15:0] w_load_raw;
    logic        w_load_zero;
    logic [15:0] w_load_val;

    assign w_step_pulse = w_step & ~r_step_prev;
    assign w_load       = w_load_lo | w_load_hi;
    // run overrides step; a load cycle never advances (load is checked first)
    assign w_advance    = w_run | w_step_pulse;

    assign w_next = r_state[0] ? ((r_state >> 1) ^ TAPS) : (r_state >> 1);

    assign w_load_raw  = {w_load_hi ? uio_in : r_state[15:8],
                          w_load_lo ? uio_in : r_state[7:0]};
    // An all-zero Galois LFSR never leaves zero, so a zero load is forced to 1
    assign w_load_zero = (w_load_raw == 16'h0000);
    assign w_load_val  = w_load_zero ? 16'h0001 : w_load_raw;

    // ------------------------------------------------------------------
    // Main state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= SEED;
            r_start     <= SEED;
            r_zero      <= 1'b0;
            r_wrap      <= 1'b0;
            r_step_prev <= 1'b0;
        end else begin
            // Edge detector tracks the pin even while the tile is disabled
            r_step_prev <= w_step;
            if (ena) begin
                if (w_load) begin
                    r_state <= w_load_val;
                    r_start <= w_load_val;
                    r_wrap  <= 1'b0;
                    if (w_load_zero) begin
                        r_zero <= 1'b1;
                    end
                end else if (w_advance) begin
                    r_state <= w_next;
                    if (w_next == r_start) begin
                        r_wrap <= 1'b1;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional history of shifted-out bits
    // ------------------------------------------------------------------
    logic [7:0] w_hist_out;

`ifdef LFSR_HISTORY_EN
    logic [7:0] r_hist;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist <= 8'h00;
        end else if (ena && !w_load && w_advance) begin
            r_hist <= {r_hist[6:0], r_state[0]};
        end
    end

    assign w_hist_out = r_hist;
`else
    assign w_hist_out = 8'h00;
`endif

    // ------------------------------------------------------------------
    // Output mux (combinational on out_sel, registered sources)
    // ------------------------------------------------------------------
    logic [7:0] w_status;

    assign w_status = {5'b00000, r_wrap, r_zero, (w_run & ena)};

    always_comb begin
        uo_out = w_hist_out;
        case (w_out_sel)
            c_SEL_LO:     uo_out = r_state[7:0];
            c_SEL_HI:     uo_out = r_state[15:8];
            c_SEL_STATUS: uo_out = w_status;
            default:      uo_out = w_hist_out;
        endcase
    end

    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_tt_um_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : tb_tt_um_lfsr
// Description : Self-checking bench for tt_um_lfsr. A behavioural model of
//               the generator is stepped alongside the DUT and every observed
//               output byte is compared with it, plus fixed reference values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tt_um_lfsr;

    localparam int c_SEED = 16'hACE1;
    localparam int c_TAPS = 16'hB400;

    logic       clk;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int errors;
    int checks;

    // Behavioural model
    int m_state;
    int m_start;
    int m_hist;
    bit m_zero;
    bit m_wrap;
    bit m_step_prev;

    tt_um_lfsr dut (
        .clk    (clk),
        .rst    (rst),
        .ena    (ena),
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One LFSR advance computed arithmetically from the polynomial rule
    task automatic model_advance();
        int nxt;
        if ((m_state % 2) == 1) nxt = (m_state / 2) ^ c_TAPS;
        else                    nxt = m_state / 2;
        m_hist = ((m_hist * 2) + (m_state % 2)) % 256;
        if (nxt == m_start) m_wrap = 1'b1;
        m_state = nxt;
    endtask

    task automatic model_update(input logic [7:0] ui, input logic [7:0] uio,
                                input logic en, input logic r);
        bit pulse;
        int v;
        if (r) begin
            m_state = c_SEED; m_start = c_SEED; m_hist = 0;
            m_zero = 1'b0; m_wrap = 1'b0; m_step_prev = 1'b0;
        end else begin
            pulse = ui[1] && !m_step_prev;
            m_step_prev = ui[1];
            if (en) begin
                if (ui[2] || ui[3]) begin
                    v = m_state;
                    if (ui[2]) v = (v / 256) * 256 + int'(uio);
                    if (ui[3]) v = int'(uio) * 256 + (v % 256);
                    if (v == 0) begin
                        v = 1;
                        m_zero = 1'b1;
                    end
                    m_state = v; m_start = v; m_wrap = 1'b0;
                end else if (ui[0] || pulse) begin
                    model_advance();
                end
            end
        end
    endtask

    // Drive one clock with given inputs; DUT and model see the same edge
    task automatic cycle(input logic [7:0] ui, input logic [7:0] uio,
                         input logic en, input logic r);
        ui_in = ui; uio_in = uio; ena = en; rst = r;
        @(posedge clk);
        model_update(ui, uio, en, r);
        #1;
    endtask

    // Read all output views by sweeping out_sel, then restore it
    task automatic peek(output logic [15:0] st, output logic [7:0] status,
                        output logic [7:0] hist);
        logic [7:0] saved;
        saved = ui_in;
        ui_in = {saved[7:6], 2'b00, saved[3:0]}; #1; st[7:0]  = uo_out;
        ui_in = {saved[7:6], 2'b01, saved[3:0]}; #1; st[15:8] = uo_out;
        ui_in = {saved[7:6], 2'b10, saved[3:0]}; #1; status   = uo_out;
        ui_in = {saved[7:6], 2'b11, saved[3:0]}; #1; hist     = uo_out;
        ui_in = saved;
    endtask

    function automatic logic [7:0] exp_status();
        return {5'b0, m_wrap, m_zero, ui_in[0] & ena};
    endfunction

    function automatic logic [7:0] exp_hist();
`ifdef LFSR_HISTORY_EN
        return m_hist[7:0];
`else
        return 8'h00;
`endif
    endfunction

    task automatic test_reset();
        logic [15:0] st; logic [7:0] s; logic [7:0] h;
        cycle(8'h00, 8'h00, 1'b1, 1'b1);
        cycle(8'h00, 8'h00, 1'b1, 1'b1);
        ui_in = 8'h00; rst = 1'b0; #1;
        peek(st, s, h);
        checks++; if (st[7:0] !== 8'hE1) begin errors++; $display("FAIL reset_lo got %h want e1", st[7:0]); end
        checks++; if (st[15:8] !== 8'hAC) begin errors++; $display("FAIL reset_hi got %h want ac", st[15:8]); end
        checks++; if (s !== 8'h00) begin errors++; $display("FAIL reset_status got %h want 00", s); end
        checks++; if (h !== 8'h00) begin errors++; $display("FAIL reset_hist got %h want 00", h); end
        checks++; if (uio_oe !== 8'h00 || uio_out !== 8'h00) begin
            errors++; $display("FAIL reset_uio got oe=%h out=%h want 00/00", uio_oe, uio_out);
        end
    endtask

    task automatic test_run_sequence();
        logic [15:0] st; logic [7:0] s; logic [7:0] h;
        logic [15:0] ref_seq [6];
        ref_seq = '{16'hE270, 16'h7138, 16'h389C, 16'h1C4E, 16'h0E27, 16'hB313};
        cycle(8'h00, 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            cycle(8'h01, 8'h00, 1'b1, 1'b0);
            peek(st, s, h);
            checks++; if (st !== ref_seq[i]) begin errors++; $display("FAIL run_seq[%0d] got %h want %h", i, st, ref_seq[i]); end
        end
        peek(st, s, h);
`ifdef LFSR_HISTORY_EN
        checks++; if (h !== 8'h21) begin errors++; $display("FAIL run_hist got %h want 21", h); end
`else
        checks++; if (h !== 8'h00) begin errors++; $display("FAIL run_hist got %h want 00", h); end
`endif
        checks++; if (s !== 8'h01) begin errors++; $display("FAIL run_status got %h want 01", s); end
    endtask

    task automatic test_step_edge();
        logic [15:0] st; logic [7:0] s; logic [7:0] h;
        cycle(8'h00, 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) cycle(8'h02, 8'h00, 1'b1, 1'b0);
        peek(st, s, h);
        checks++; if (st !== 16'hE270) begin errors++; $display("FAIL step_hold got %h want e270", st); end
        cycle(8'h00, 8'h00, 1'b1, 1'b0);
        cycle(8'h02, 8'h00, 1'b1, 1'b0);
        cycle(8'h02, 8'h00, 1'b1, 1'b0);
        peek(st, s, h);
        checks++; if (st !== 16'h7138) begin errors++; $display("FAIL step_reraise got %h want 7138", st); end
    endtask

    task automatic test_load_zero_guard();
        logic [15:0] st; logic [7:0] s; logic [7:0] h;
        cycle(8'h00, 8'h00, 1'b1, 1'b1);
        cycle(8'h0C, 8'h00, 1'b1, 1'b0);
        ui_in = 8'h00; #1;
        peek(st, s, h);
        checks++; if (st !== 16'h0001) begin errors++; $display("FAIL zero_guard_state got %h want 0001", st); end
        checks++; if (s !== 8'h02) begin errors++; $display("FAIL zero_guard_status got %h want 02", s); end
        // load_hi together with run: load wins, no advance
        cycle(8'h09, 8'h5A, 1'b1, 1'b0);
        peek(st, s, h);
        checks++; if (st !== 16'h5A01) begin errors++; $display("FAIL load_hi got %h want 5a01", st); end
        checks++; if (s !== 8'h03) begin errors++; $display("FAIL load_hi_status got %h want 03", s); end
    endtask

    task automatic test_wrap_period();
        logic [15:0] st; logic [7:0] s; logic [7:0] h;
        cycle(8'h00, 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 65535; i++) cycle(8'h01, 8'h00, 1'b1, 1'b0);
        peek(st, s, h);
        checks++; if (st !== 16'hACE1) begin errors++; $display("FAIL wrap_state got %h want ace1", st); end
        checks++; if (s !== 8'h05) begin errors++; $display("FAIL wrap_status got %h want 05", s); end
        checks++; if (st !== m_state[15:0]) begin errors++; $display("FAIL wrap_model got %h want %h", st, m_state[15:0]); end
        for (int i = 0; i < 10; i++) cycle(8'h01, 8'h00, 1'b0, 1'b0);
        peek(st, s, h);
        checks++; if (st !== 16'hACE1) begin errors++; $display("FAIL ena_hold_state got %h want ace1", st); end
        checks++; if (s !== 8'h04) begin errors++; $display("FAIL ena_hold_status got %h want 04", s); end
    endtask

    task automatic test_random();
        logic [15:0] st; logic [7:0] s; logic [7:0] h;
        logic [7:0] ui; logic [7:0] uio; logic en; logic r;
        for (int i = 0; i < 400; i++) begin
            ui  = 8'($urandom) & 8'hF2;
            if ($urandom_range(0, 7) == 0) ui[0] = 1'b1;
            if ($urandom_range(0, 7) == 0) ui[2] = 1'b1;
            if ($urandom_range(0, 7) == 0) ui[3] = 1'b1;
            uio = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            en  = ($urandom_range(0, 5) != 0);
            r   = ($urandom_range(0, 99) == 0);
            cycle(ui, uio, en, r);
            rst = 1'b0;
            peek(st, s, h);
            checks++;
            if (st !== m_state[15:0] || s !== exp_status() || h !== exp_hist()) begin
                errors++;
                $display("FAIL random[%0d] got st=%h status=%h hist=%h want st=%h status=%h hist=%h",
                         i, st, s, h, m_state[15:0], exp_status(), exp_hist());
            end
            checks++;
            if (uio_oe !== 8'h00 || uio_out !== 8'h00) begin
                errors++; $display("FAIL random_uio[%0d] got oe=%h out=%h want 00/00", i, uio_oe, uio_out);
            end
        end
    endtask

    initial begin
        errors = 0; checks = 0;
        rst = 1'b1; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
        test_reset();
        test_run_sequence();
        test_step_edge();
        test_load_zero_guard();
        test_wrap_period();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tt_um_lfsr.md
Name: tt_um_lfsr

Overview:
- 16-bit Galois LFSR pseudo-random generator wrapped in the standard TinyTapeout user-tile interface.
- Supports free-running or single-step advance, byte-wise seed load from the bidirectional pins, all-zero lock-up guard, period-wrap detection, and a selectable output byte.
- Top-level user project; all I/O maps directly to tile pins.

Parameters:
- SEED, 16'hACE1, state value loaded at reset (must be non-zero).
- TAPS, 16'hB400, Galois feedback mask; default is x^16+x^14+x^13+x^11+1, which is maximal length (period 65535).

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst  input  1  synchronous reset, active-high.
- ena  input  1  tile enable; when 0, all state holds.
- ui_in  input  8  control:
  - [0] run
  - [1] step
  - [2] load_lo
  - [3] load_hi
  - [5:4] out_sel
  - [7:6] reserved, ignored
- uo_out  output  8  selected output byte.
- uio_in  input  8  seed byte for loads.
- uio_out  output  8  constant 8'h00.
- uio_oe  output  8  constant 8'h00; all uio pins are inputs.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - state=SEED, start=SEED.
  - hist=8'h00, zero_flag=0, wrap_flag=0, step_prev=0.
- step_prev <= ui_in[1] every non-reset cycle, regardless of ena.
- step_pulse = ui_in[1] & ~step_prev.
- Advance step: if state[0], next = (state>>1) ^ TAPS; otherwise next = state>>1.
- Priority per cycle (when ena=1):
  - Load first: if load_lo or load_hi is set, replace the selected bytes of state with uio_in; no advance that cycle.
  - Both loads in the same cycle are legal; both bytes then take uio_in.
  - Else if run=1: advance once per cycle.
  - Else if step_pulse: advance exactly once per rising edge of step. Holding step high does not repeat.
  - With run=1, step is ignored.
- Zero guard:
  - If a load would yield state 16'h0000, state becomes 16'h0001 and zero_flag is set.
  - zero_flag is sticky and cleared only by reset.
- Load side effects:
  - start <= resulting (guarded) state.
  - wrap_flag cleared.
- Wrap detection: on an advance where next == start, wrap_flag sets (sticky until next load or reset).
- History: on each advance, hist <= {hist[6:0], state[0]}; state[0] is the pre-advance LSB.
- ena=0: no load, no advance, and no flag updates.
- uo_out is registered-state based, combinational mux by out_sel:
  - 00 state[7:0]
  - 01 state[15:8]
  - 10 status = {5'b0, wrap_flag, zero_flag, run&ena}
  - 11 hist (see Optional Feature)
- Output changes are visible the cycle after the causing edge. out_sel changes take effect combinationally.

Optional Feature:
- Macro LFSR_HISTORY_EN.
- Defined: hist register exists; out_sel=11 returns hist.
- Undefined: no hist register; out_sel=11 returns 8'h00.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, ena=1, ui_in=0 -> out_sel=00 gives 0xE1; out_sel=01 gives 0xAC; out_sel=10 gives 0x00.
- run=1 for 6 cycles -> state sequence 0xE270, 0x7138, 0x389C, 0x1C4E, 0x0E27, 0xB313. With LFSR_HISTORY_EN, out_sel=11 then gives 0x21.
- After reset, run=0, step held high 5 cycles -> exactly one advance, state 0xE270; release and re-raise step -> 0x7138.
- uio_in=0x00, load_lo=load_hi=1 for one cycle -> state 0x0001, status 0x02. Then uio_in=0x5A with load_hi only -> state 0x5A01, no advance.
- From reset, run=1 for 65535 cycles -> state 0xACE1 again, status 0x05. ena=0 for 10 cycles -> state unchanged, status 0x04.
- Build without LFSR_HISTORY_EN, run 6 cycles, out_sel=11 -> 0x00. uio_oe=0x00 and uio_out=0x00 at all times.
